// File: rtl/lvds_tx.sv
`timescale 1ns/1ps
// I/Q word serializer: pops 32-bit words and sends 16 MSB-first 2-bit symbols with I/Q sync framing.
// The first symbol appears 3 cycles after the pull decision; back-to-back words stream every 16 cycles while the FIFO is non-empty, otherwise the link idles at 00.
module lvds_tx (
    input  logic        i_ddr_clk,
    input  logic        i_rst_b,
    input  logic        i_tx_en,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_read_clk,
    output logic        o_fifo_pull,
    output logic [1:0]  o_ddr_data,
    output logic        o_underrun,
    output logic [1:0]  o_debug_state
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FETCH   = 2'b01;
    localparam logic [1:0] I_PHASE = 2'b11;
    localparam logic [1:0] Q_PHASE = 2'b10;

    localparam logic [1:0] I_SYNC  = 2'b10;
    localparam logic [1:0] Q_SYNC  = 2'b01;

    // Counter value in Q_PHASE while symbol 15 / symbol 13 is on the link
    localparam logic [2:0] CNT_LAST     = 3'd0;
    localparam logic [2:0] CNT_DECISION = 3'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        pull_q, pull_d;
    logic        cont_q, cont_d;
    logic        urun_pend_q, urun_pend_d;
    logic        underrun_q, underrun_d;

    logic [31:0] framed_word;
    logic        can_fetch;
    logic        unused_sync_bits;

    // The sync positions of the FIFO word are discarded and replaced on the wire
    assign framed_word      = {I_SYNC, i_fifo_data[29:16], Q_SYNC, i_fifo_data[13:0]};
    assign unused_sync_bits = ^{i_fifo_data[31:30], i_fifo_data[15:14]};
    assign can_fetch        = i_tx_en && !i_fifo_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        pull_d      = 1'b0;
        cont_d      = cont_q;
        urun_pend_d = urun_pend_q;
        underrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pull_q) begin
                    state_d = FETCH;
                end else if (can_fetch) begin
                    pull_d = 1'b1;
                end
            end

            FETCH: begin
                shift_d = framed_word;
                cnt_d   = 3'd7;
                state_d = I_PHASE;
            end

            I_PHASE: begin
                shift_d = {shift_q[29:0], 2'b00};
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd7;
                    state_d = Q_PHASE;
                end
            end

            Q_PHASE: begin
                shift_d = {shift_q[29:0], 2'b00};
                cnt_d   = cnt_q - 3'd1;

                // Edge starting symbol 14: decide whether the next word follows seamlessly
                if (cnt_q == CNT_DECISION) begin
                    cont_d      = can_fetch;
                    pull_d      = can_fetch;
                    urun_pend_d = i_tx_en && i_fifo_empty;
                end

                if (cnt_q == CNT_LAST) begin
                    cont_d      = 1'b0;
                    urun_pend_d = 1'b0;
                    if (cont_q) begin
                        shift_d = framed_word;
                        cnt_d   = 3'd7;
                        state_d = I_PHASE;
                    end else begin
                        shift_d    = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                        underrun_d = urun_pend_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
                cont_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            pull_q      <= 1'b0;
            cont_q      <= 1'b0;
            urun_pend_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            pull_q      <= pull_d;
            cont_q      <= cont_d;
            urun_pend_q <= urun_pend_d;
            underrun_q  <= underrun_d;
        end
    end

    // Symbol comes straight from a flop; the shift register is all-zero whenever no word is in flight
    assign o_ddr_data      = shift_q[31:30];
    assign o_fifo_pull     = pull_q;
    assign o_underrun      = underrun_q;
    assign o_debug_state   = state_q;
    assign o_fifo_read_clk = i_ddr_clk;

endmodule

// File: tb/tb_lvds_tx.sv
`timescale 1ns/1ps
// Directed and randomized bench for lvds_tx with a registered-read FIFO model and a framing receiver.
module tb_lvds_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        empty;
    logic [31:0] fdata;
    logic        o_fifo_read_clk;
    logic        o_fifo_pull;
    logic [1:0]  o_ddr_data;
    logic        o_underrun;
    logic [1:0]  o_debug_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] burst_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] stage;
    bit          pend = 1'b0;

    bit          rx_on = 1'b0;
    int          rx_k = 0;
    int          rx_cnt = 0;
    logic [31:0] rx_w;

    lvds_tx dut (
        .i_ddr_clk      (clk),
        .i_rst_b        (rst_n),
        .i_tx_en        (en),
        .i_fifo_empty   (empty),
        .i_fifo_data    (fdata),
        .o_fifo_read_clk(o_fifo_read_clk),
        .o_fifo_pull    (o_fifo_pull),
        .o_ddr_data     (o_ddr_data),
        .o_underrun     (o_underrun),
        .o_debug_state  (o_debug_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Symbol k of a word on the link: sync pairs at 0 and 8, data pairs MSB-first elsewhere
    function automatic logic [1:0] exp_sym(input logic [31:0] w, input int k);
        logic [1:0] s;
        if (k == 0)      s = 2'b10;
        else if (k == 8) s = 2'b01;
        else             s = w[31-2*k -: 2];
        return s;
    endfunction

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        empty = 1'b0;
    endtask

    // FIFO pop on a pull; data shows up just after the following rising edge and only for one cycle
    always @(negedge clk) begin
        if (o_fifo_pull === 1'b1) begin
            check("pull_while_empty", {31'b0, empty}, 32'd0);
            if (fifo_q.size() > 0) begin
                stage = fifo_q.pop_front();
                pend  = 1'b1;
            end
            empty = (fifo_q.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend) begin
            fdata = stage;
            pend  = 1'b0;
        end else begin
            fdata = $urandom();
        end
    end

    // Receiver: hunts for the I-sync after idle 00s, then collects 16 symbols
    always @(negedge clk) begin
        logic [1:0]  s;
        logic [31:0] w;
        if (rx_on) begin
            s = o_ddr_data;
            if (rx_k == 0) begin
                if (s != 2'b00) begin
                    check("rx_start", {30'b0, s}, 32'h2);
                    rx_w = {30'b0, s};
                    rx_k = 1;
                end
            end else begin
                rx_w = {rx_w[29:0], s};
                rx_k++;
                if (rx_k == 16) begin
                    rx_k = 0;
                    rx_cnt++;
                    if (sent_q.size() == 0) begin
                        check("rx_extra_word", rx_w, 32'h0);
                    end else begin
                        w = sent_q.pop_front();
                        check("rx_word", rx_w, {2'b10, w[29:16], 2'b01, w[13:0]});
                    end
                end
            end
        end
    end

    // Called at a negedge with words queued and enable set; follows the burst until idle
    task automatic expect_burst(input int nwords, input int drop_k, input bit exp_urun);
        logic [31:0] w;
        @(negedge clk);
        check("pull_cycle_pull", {31'b0, o_fifo_pull}, 32'd1);
        check("pull_cycle_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("pull_cycle_state", {30'b0, o_debug_state}, 32'd0);
        @(negedge clk);
        check("fetch_pull", {31'b0, o_fifo_pull}, 32'd0);
        check("fetch_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("fetch_state", {30'b0, o_debug_state}, 32'd1);
        for (int i = 0; i < nwords; i++) begin
            w = burst_q.pop_front();
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                check($sformatf("w%0d_sym%0d", i, k), {30'b0, o_ddr_data}, {30'b0, exp_sym(w, k)});
                check($sformatf("w%0d_pull%0d", i, k), {31'b0, o_fifo_pull},
                      (k == 14 && i < nwords - 1) ? 32'd1 : 32'd0);
                check($sformatf("w%0d_urun%0d", i, k), {31'b0, o_underrun}, 32'd0);
                if (i == 0 && k == drop_k) en = 1'b0;
            end
        end
        @(negedge clk);
        check("end_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("end_underrun", {31'b0, o_underrun}, {31'b0, exp_urun});
        check("end_state", {30'b0, o_debug_state}, 32'd0);
        check("end_pull", {31'b0, o_fifo_pull}, 32'd0);
        @(negedge clk);
        check("after_underrun", {31'b0, o_underrun}, 32'd0);
        check("after_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("after_pull", {31'b0, o_fifo_pull}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int g;
        bit abort;

        rst_n = 1'b0;
        en    = 1'b0;
        empty = 1'b1;
        fdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("rst_pull", {31'b0, o_fifo_pull}, 32'd0);
        check("rst_underrun", {31'b0, o_underrun}, 32'd0);
        check("rst_state", {30'b0, o_debug_state}, 32'd0);
        check("read_clk_low", {31'b0, o_fifo_read_clk}, {31'b0, clk});
        @(posedge clk);
        #1;
        check("read_clk_high", {31'b0, o_fifo_read_clk}, {31'b0, clk});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_pull", {31'b0, o_fifo_pull}, 32'd0);

        // Single word, then underrun because the FIFO runs dry with enable held
        en = 1'b1;
        push(32'h3FFF_C000);
        burst_q.push_back(32'h3FFF_C000);
        expect_burst(1, -1, 1'b1);

        // Two pre-filled words stream back-to-back
        push(32'h0000_0001);
        push(32'hFFFF_FFFF);
        burst_q.push_back(32'h0000_0001);
        burst_q.push_back(32'hFFFF_FFFF);
        expect_burst(2, -1, 1'b1);

        // Three random words
        for (int i = 0; i < 3; i++) begin
            w = $urandom();
            push(w);
            burst_q.push_back(w);
        end
        expect_burst(3, -1, 1'b1);

        // Enable dropped during symbol 3: word completes, no pull, no underrun
        for (int i = 0; i < 2; i++) begin
            w = $urandom();
            push(w);
            burst_q.push_back(w);
        end
        expect_burst(1, 3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("disabled_no_pull", {31'b0, o_fifo_pull}, 32'd0);
        end
        fifo_q.delete();
        burst_q.delete();
        empty = 1'b1;

        // Asynchronous reset during symbol 9
        w  = 32'hA5A5_5A5A;
        en = 1'b1;
        push(w);
        repeat (2) @(negedge clk);
        repeat (10) @(negedge clk);
        check("pre_reset_sym9", {30'b0, o_ddr_data}, {30'b0, exp_sym(w, 9)});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ddr", {30'b0, o_ddr_data}, 32'd0);
        check("async_rst_pull", {31'b0, o_fifo_pull}, 32'd0);
        check("async_rst_urun", {31'b0, o_underrun}, 32'd0);
        check("async_rst_state", {30'b0, o_debug_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_ddr", {30'b0, o_ddr_data}, 32'd0);
            check("post_rst_pull", {31'b0, o_fifo_pull}, 32'd0);
        end

        // Loopback: 1000 random words through the receiver model
        rx_k   = 0;
        rx_cnt = 0;
        rx_on  = 1'b1;
        abort  = 1'b0;
        for (int n = 0; n < 1000 && !abort; n++) begin
            @(negedge clk);
            g = 0;
            while (fifo_q.size() >= 3 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                check("lb_fifo_drain", fifo_q.size(), 32'd2);
                abort = 1'b1;
            end else begin
                if ($urandom_range(0, 49) == 0) repeat ($urandom_range(10, 40)) @(negedge clk);
                w = $urandom();
                push(w);
                sent_q.push_back(w);
            end
        end
        g = 0;
        while (rx_cnt < 1000 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("lb_count", rx_cnt, 32'd1000);
        repeat (20) @(negedge clk);
        rx_on = 1'b0;
        check("lb_sent_drained", sent_q.size(), 32'd0);
        check("lb_idle_state", {30'b0, o_debug_state}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
